// File: rtl/wb_decode_scoreboard_pkg.sv
// Shared defaults and helpers for the writeback decode / busy scoreboard block.
// The popcount helper covers register files up to 2**SB_ADDR_W_MAX entries.
package wb_sb_pkg;

    localparam int SB_ADDR_W_DEF = 5;
    localparam int SB_PORTS_DEF  = 2;
    localparam int SB_PORTS_MAX  = 4;
    localparam int SB_ADDR_W_MAX = 8;
    localparam int SB_MAX_REGS   = 1 << SB_ADDR_W_MAX;
    localparam int SB_CNT_W      = SB_ADDR_W_MAX + 1;

    function automatic logic [SB_CNT_W-1:0] popcount(input logic [SB_MAX_REGS-1:0] vec);
        logic [SB_CNT_W-1:0] count;
        count = '0;
        for (int i = 0; i < SB_MAX_REGS; i++) begin
            count = count + SB_CNT_W'(vec[i]);
        end
        return count;
    endfunction

endpackage

// File: rtl/wb_decode_scoreboard_onehot_dec.sv
// Combinational address-to-one-hot decoder for a single writeback port.
// The vector is all-zero whenever en is low.
module onehot_dec
    import wb_sb_pkg::*;
#(
    parameter  int ADDR_W   = SB_ADDR_W_DEF,
    localparam int NUM_REGS = 2 ** ADDR_W
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/wb_decode_scoreboard.sv
// Writeback write-enable decoder with per-register busy scoreboard and WAW issue stall.
// Optional macro SB_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module wb_decode_scoreboard
    import wb_sb_pkg::*;
#(
    parameter  int ADDR_W    = SB_ADDR_W_DEF,
    parameter  int NUM_PORTS = SB_PORTS_DEF,
    localparam int NUM_REGS  = 2 ** ADDR_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_addr,
    output logic                          issue_ready,
    input  logic [NUM_PORTS-1:0]          wb_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   wb_addr,
    output logic [NUM_PORTS*NUM_REGS-1:0] wr_en,
    output logic [NUM_REGS-1:0]           busy,
    output logic [ADDR_W:0]               busy_cnt,
    output logic                          collision_err,
    input  logic                          err_clr
`ifdef SB_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    logic [NUM_PORTS-1:0][NUM_REGS-1:0] w_dec;
    logic [NUM_PORTS-1:0][NUM_REGS-1:0] w_kept;
    logic [NUM_REGS-1:0]                w_wbHit;
    logic [NUM_REGS-1:0]                w_issueSet;
    logic [NUM_REGS-1:0]                w_busyNext;
    logic                               w_collision;
    logic                               w_issueAccept;

    logic [NUM_PORTS*NUM_REGS-1:0]      r_wrEn;
    logic [NUM_REGS-1:0]                r_busy;
    logic [ADDR_W:0]                    r_busyCnt;
    logic                               r_collisionErr;

    // Register 0 is never a write target, so it is masked before decode.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = wb_addr[p*ADDR_W +: ADDR_W];
        onehot_dec #(
            .ADDR_W (ADDR_W)
        ) u_dec (
            .addr   (w_addr),
            .en     (wb_valid[p] && (w_addr != '0)),
            .onehot (w_dec[p])
        );
    end

    // Lower-index port wins; a later port hitting an already-claimed register is dropped.
    always_comb begin
        w_wbHit     = '0;
        w_collision = 1'b0;
        w_kept      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_kept[p]   = w_dec[p] & ~w_wbHit;
            w_collision = w_collision | (|(w_dec[p] & w_wbHit));
            w_wbHit     = w_wbHit | w_dec[p];
        end
    end

    // A writeback landing this cycle resolves the hazard, so issue may proceed.
    assign issue_ready   = !r_busy[issue_addr] || w_wbHit[issue_addr] || (issue_addr == '0);
    assign w_issueAccept = issue_valid && issue_ready && (issue_addr != '0);

    always_comb begin
        w_issueSet = '0;
        if (w_issueAccept) begin
            w_issueSet[issue_addr] = 1'b1;
        end
    end

    assign w_busyNext = (r_busy & ~w_wbHit) | w_issueSet;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrEn         <= '0;
            r_busy         <= '0;
            r_busyCnt      <= '0;
            r_collisionErr <= 1'b0;
        end else begin
            r_wrEn    <= w_kept;
            r_busy    <= w_busyNext;
            r_busyCnt <= (ADDR_W+1)'(popcount(SB_MAX_REGS'(w_busyNext)));
            if (w_collision) begin
                r_collisionErr <= 1'b1;
            end else if (err_clr) begin
                r_collisionErr <= 1'b0;
            end
        end
    end

    assign wr_en         = r_wrEn;
    assign busy          = r_busy;
    assign busy_cnt      = r_busyCnt;
    assign collision_err = r_collisionErr;

`ifdef SB_STALL_CNT_EN
    logic [15:0] r_stallCnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= '0;
        end else if (err_clr) begin
            r_stallCnt <= '0;
        end else if (issue_valid && !issue_ready && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_wb_decode_scoreboard.sv
// Self-checking bench for wb_decode_scoreboard: a behavioural model pushes expected
// outputs to a queue when stimulus is driven; they are popped after the next edge.
module tb_wb_decode_scoreboard;

    localparam int AW = 5;
    localparam int NP = 2;
    localparam int NR = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              issue_valid;
    logic [AW-1:0]     issue_addr;
    logic              issue_ready;
    logic [NP-1:0]     wb_valid;
    logic [NP*AW-1:0]  wb_addr;
    logic [NP*NR-1:0]  wr_en;
    logic [NR-1:0]     busy;
    logic [AW:0]       busy_cnt;
    logic              collision_err;
    logic              err_clr;
`ifdef SB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       mStall;
`endif

    wb_decode_scoreboard #(
        .ADDR_W    (AW),
        .NUM_PORTS (NP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_addr    (issue_addr),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wr_en         (wr_en),
        .busy          (busy),
        .busy_cnt      (busy_cnt),
        .collision_err (collision_err),
        .err_clr       (err_clr)
`ifdef SB_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NP*NR-1:0] wrEn;
        logic [NR-1:0]    busy;
        logic [AW:0]      cnt;
        logic             coll;
    } exp_t;

    typedef struct {
        logic          iv;
        logic [AW-1:0] ia;
        logic [NP-1:0] wv;
        logic [NP*AW-1:0] wa;
        logic          clr;
    } stim_t;

    exp_t        sbq[$];
    int          nTotal = 0;
    int          nBad   = 0;
    logic [NR-1:0] mBusy;
    logic        mColl;
    logic        expReady;

    function automatic logic [NP*AW-1:0] pk(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        return {a1, a0};
    endfunction

    // Drives one cycle of inputs and advances the reference model, queueing its prediction.
    task automatic applyStimulus(input stim_t s);
        logic [NR-1:0]    seen;
        logic [NP*NR-1:0] wr;
        logic [NR-1:0]    nb;
        logic             coll;
        logic [AW-1:0]    a;
        exp_t             e;
        issue_valid = s.iv;
        issue_addr  = s.ia;
        wb_valid    = s.wv;
        wb_addr     = s.wa;
        err_clr     = s.clr;
        seen = '0;
        wr   = '0;
        coll = 1'b0;
        for (int p = 0; p < NP; p++) begin
            a = s.wa[p*AW +: AW];
            if (s.wv[p] && (a != 0)) begin
                if (seen[a]) begin
                    coll = 1'b1;
                end else begin
                    seen[a] = 1'b1;
                    wr[p*NR + int'(a)] = 1'b1;
                end
            end
        end
        expReady = !mBusy[s.ia] || seen[s.ia] || (s.ia == 0);
`ifdef SB_STALL_CNT_EN
        if (s.clr) mStall = '0;
        else if (s.iv && !expReady && mStall != 16'hFFFF) mStall = mStall + 16'd1;
`endif
        nb = mBusy & ~seen;
        if (s.iv && expReady && (s.ia != 0)) nb[s.ia] = 1'b1;
        if (coll) mColl = 1'b1;
        else if (s.clr) mColl = 1'b0;
        mBusy  = nb;
        e.wrEn = wr;
        e.busy = nb;
        e.cnt  = (AW+1)'($countones(nb));
        e.coll = mColl;
        sbq.push_back(e);
    endtask

    task automatic modelReset();
        mBusy = '0;
        mColl = 1'b0;
`ifdef SB_STALL_CNT_EN
        mStall = '0;
`endif
        sbq.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'($urandom);
            issue_addr  = AW'($urandom);
            wb_valid    = NP'($urandom);
            wb_addr     = (NP*AW)'($urandom);
            err_clr     = 1'($urandom);
            @(posedge clock); #1;
            nTotal += 4;
            if (wr_en !== '0) begin nBad++; $display("[TB] FAIL reset.wr_en[%0d]: got %h want 0", i, wr_en); end
            if (busy !== '0) begin nBad++; $display("[TB] FAIL reset.busy[%0d]: got %h want 0", i, busy); end
            if (busy_cnt !== '0) begin nBad++; $display("[TB] FAIL reset.busy_cnt[%0d]: got %0d want 0", i, busy_cnt); end
            if (collision_err !== 1'b0) begin nBad++; $display("[TB] FAIL reset.coll[%0d]: got %b want 0", i, collision_err); end
        end
        issue_valid = 1'b0; issue_addr = '0; wb_valid = '0; wb_addr = '0; err_clr = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            nTotal += 3;
            if (wr_en !== '0) begin nBad++; $display("[TB] FAIL release.wr_en[%0d]: got %h want 0", i, wr_en); end
            if (busy !== '0) begin nBad++; $display("[TB] FAIL release.busy[%0d]: got %h want 0", i, busy); end
            if (busy_cnt !== '0) begin nBad++; $display("[TB] FAIL release.busy_cnt[%0d]: got %0d want 0", i, busy_cnt); end
        end
    endtask

    task automatic test_basic();
        stim_t t[3];
        exp_t  e;
        t[0] = '{1'b1, 5'd7, 2'b00, 10'd0, 1'b0};
        t[1] = '{1'b0, 5'd0, 2'b01, pk(5'd0, 5'd7), 1'b0};
        t[2] = '{1'b0, 5'd0, 2'b00, 10'd0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(t[i]); #1;
            nTotal++;
            if (issue_ready !== expReady) begin nBad++; $display("[TB] FAIL basic.ready[%0d]: got %b want %b", i, issue_ready, expReady); end
            @(posedge clock); #1;
            e = sbq.pop_front();
            nTotal += 4;
            if (wr_en !== e.wrEn) begin nBad++; $display("[TB] FAIL basic.wr_en[%0d]: got %h want %h", i, wr_en, e.wrEn); end
            if (busy !== e.busy) begin nBad++; $display("[TB] FAIL basic.busy[%0d]: got %h want %h", i, busy, e.busy); end
            if (busy_cnt !== e.cnt) begin nBad++; $display("[TB] FAIL basic.busy_cnt[%0d]: got %0d want %0d", i, busy_cnt, e.cnt); end
            if (collision_err !== e.coll) begin nBad++; $display("[TB] FAIL basic.coll[%0d]: got %b want %b", i, collision_err, e.coll); end
        end
    endtask

    task automatic test_waw();
        stim_t t[6];
        exp_t  e;
        t[0] = '{1'b1, 5'd5, 2'b00, 10'd0, 1'b0};
        t[1] = '{1'b1, 5'd5, 2'b00, 10'd0, 1'b0};
        t[2] = '{1'b1, 5'd5, 2'b10, pk(5'd5, 5'd0), 1'b0};
        t[3] = '{1'b0, 5'd0, 2'b00, 10'd0, 1'b0};
        t[4] = '{1'b0, 5'd0, 2'b01, pk(5'd0, 5'd5), 1'b0};
        t[5] = '{1'b0, 5'd0, 2'b00, 10'd0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(t[i]); #1;
            nTotal++;
            if (issue_ready !== expReady) begin nBad++; $display("[TB] FAIL waw.ready[%0d]: got %b want %b", i, issue_ready, expReady); end
            @(posedge clock); #1;
            e = sbq.pop_front();
            nTotal += 4;
            if (wr_en !== e.wrEn) begin nBad++; $display("[TB] FAIL waw.wr_en[%0d]: got %h want %h", i, wr_en, e.wrEn); end
            if (busy !== e.busy) begin nBad++; $display("[TB] FAIL waw.busy[%0d]: got %h want %h", i, busy, e.busy); end
            if (busy_cnt !== e.cnt) begin nBad++; $display("[TB] FAIL waw.busy_cnt[%0d]: got %0d want %0d", i, busy_cnt, e.cnt); end
            if (collision_err !== e.coll) begin nBad++; $display("[TB] FAIL waw.coll[%0d]: got %b want %b", i, collision_err, e.coll); end
        end
    endtask

    task automatic test_collision();
        stim_t t[6];
        exp_t  e;
        t[0] = '{1'b0, 5'd0, 2'b11, pk(5'd12, 5'd12), 1'b0};
        t[1] = '{1'b0, 5'd0, 2'b00, 10'd0, 1'b0};
        t[2] = '{1'b0, 5'd0, 2'b00, 10'd0, 1'b1};
        t[3] = '{1'b0, 5'd0, 2'b11, pk(5'd20, 5'd20), 1'b1};
        t[4] = '{1'b0, 5'd0, 2'b00, 10'd0, 1'b1};
        t[5] = '{1'b0, 5'd0, 2'b11, pk(5'd3, 5'd9), 1'b0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(t[i]); #1;
            nTotal++;
            if (issue_ready !== expReady) begin nBad++; $display("[TB] FAIL coll.ready[%0d]: got %b want %b", i, issue_ready, expReady); end
            @(posedge clock); #1;
            e = sbq.pop_front();
            nTotal += 4;
            if (wr_en !== e.wrEn) begin nBad++; $display("[TB] FAIL coll.wr_en[%0d]: got %h want %h", i, wr_en, e.wrEn); end
            if (busy !== e.busy) begin nBad++; $display("[TB] FAIL coll.busy[%0d]: got %h want %h", i, busy, e.busy); end
            if (busy_cnt !== e.cnt) begin nBad++; $display("[TB] FAIL coll.busy_cnt[%0d]: got %0d want %0d", i, busy_cnt, e.cnt); end
            if (collision_err !== e.coll) begin nBad++; $display("[TB] FAIL coll.flag[%0d]: got %b want %b", i, collision_err, e.coll); end
        end
    endtask

    task automatic test_reg0();
        stim_t t[4];
        exp_t  e;
        t[0] = '{1'b1, 5'd9, 2'b00, 10'd0, 1'b0};
        t[1] = '{1'b1, 5'd0, 2'b11, pk(5'd0, 5'd0), 1'b0};
        t[2] = '{1'b1, 5'd0, 2'b00, 10'd0, 1'b0};
        t[3] = '{1'b0, 5'd0, 2'b10, pk(5'd9, 5'd0), 1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(t[i]); #1;
            nTotal++;
            if (issue_ready !== expReady) begin nBad++; $display("[TB] FAIL reg0.ready[%0d]: got %b want %b", i, issue_ready, expReady); end
            @(posedge clock); #1;
            e = sbq.pop_front();
            nTotal += 4;
            if (wr_en !== e.wrEn) begin nBad++; $display("[TB] FAIL reg0.wr_en[%0d]: got %h want %h", i, wr_en, e.wrEn); end
            if (busy !== e.busy) begin nBad++; $display("[TB] FAIL reg0.busy[%0d]: got %h want %h", i, busy, e.busy); end
            if (busy_cnt !== e.cnt) begin nBad++; $display("[TB] FAIL reg0.busy_cnt[%0d]: got %0d want %0d", i, busy_cnt, e.cnt); end
            if (collision_err !== e.coll) begin nBad++; $display("[TB] FAIL reg0.coll[%0d]: got %b want %b", i, collision_err, e.coll); end
        end
    endtask

    task automatic test_random();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 300; i++) begin
            s.iv  = 1'($urandom_range(0, 1));
            s.ia  = AW'($urandom_range(0, 7));
            s.wv  = NP'($urandom);
            s.wa  = pk(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            s.clr = ($urandom_range(0, 15) == 0);
            applyStimulus(s); #1;
            nTotal++;
            if (issue_ready !== expReady) begin nBad++; $display("[TB] FAIL rand.ready[%0d]: got %b want %b", i, issue_ready, expReady); end
            @(posedge clock); #1;
            e = sbq.pop_front();
            nTotal += 4;
            if (wr_en !== e.wrEn) begin nBad++; $display("[TB] FAIL rand.wr_en[%0d]: got %h want %h", i, wr_en, e.wrEn); end
            if (busy !== e.busy) begin nBad++; $display("[TB] FAIL rand.busy[%0d]: got %h want %h", i, busy, e.busy); end
            if (busy_cnt !== e.cnt) begin nBad++; $display("[TB] FAIL rand.busy_cnt[%0d]: got %0d want %0d", i, busy_cnt, e.cnt); end
            if (collision_err !== e.coll) begin nBad++; $display("[TB] FAIL rand.coll[%0d]: got %b want %b", i, collision_err, e.coll); end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s;
        s = '{1'b1, 5'd4, 2'b11, pk(5'd6, 5'd6), 1'b0};
        applyStimulus(s);
        #2 reset = 1'b0;
        #1;
        nTotal += 4;
        if (wr_en !== '0) begin nBad++; $display("[TB] FAIL midrst.wr_en: got %h want 0", wr_en); end
        if (busy !== '0) begin nBad++; $display("[TB] FAIL midrst.busy: got %h want 0", busy); end
        if (busy_cnt !== '0) begin nBad++; $display("[TB] FAIL midrst.busy_cnt: got %0d want 0", busy_cnt); end
        if (collision_err !== 1'b0) begin nBad++; $display("[TB] FAIL midrst.coll: got %b want 0", collision_err); end
        @(posedge clock); #1;
        nTotal += 2;
        if (wr_en !== '0) begin nBad++; $display("[TB] FAIL midrst.wr_en_edge: got %h want 0", wr_en); end
        if (collision_err !== 1'b0) begin nBad++; $display("[TB] FAIL midrst.coll_edge: got %b want 0", collision_err); end
        issue_valid = 1'b0; wb_valid = '0; wb_addr = '0; issue_addr = '0;
        modelReset();
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

`ifdef SB_STALL_CNT_EN
    task automatic test_stall_cnt();
        stim_t s;
        exp_t  e;
        s = '{1'b0, 5'd0, 2'b00, 10'd0, 1'b1};
        applyStimulus(s); @(posedge clock); #1; e = sbq.pop_front();
        s = '{1'b1, 5'd3, 2'b00, 10'd0, 1'b0};
        applyStimulus(s); @(posedge clock); #1; e = sbq.pop_front();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(s); @(posedge clock); #1; e = sbq.pop_front();
        end
        nTotal += 2;
        if (stall_cnt !== 16'd20) begin nBad++; $display("[TB] FAIL stall.cnt20: got %0d want 20", stall_cnt); end
        if (busy !== e.busy) begin nBad++; $display("[TB] FAIL stall.busy: got %h want %h", busy, e.busy); end
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(s); @(posedge clock); #1; e = sbq.pop_front();
        end
        nTotal += 2;
        if (stall_cnt !== 16'hFFFF) begin nBad++; $display("[TB] FAIL stall.sat: got %h want ffff", stall_cnt); end
        if (stall_cnt !== mStall) begin nBad++; $display("[TB] FAIL stall.model: got %h want %h", stall_cnt, mStall); end
        s = '{1'b1, 5'd3, 2'b00, 10'd0, 1'b1};
        applyStimulus(s); @(posedge clock); #1; e = sbq.pop_front();
        nTotal++;
        if (stall_cnt !== 16'd0) begin nBad++; $display("[TB] FAIL stall.clr: got %0d want 0", stall_cnt); end
    endtask
`endif

    initial begin
        issue_valid = 1'b0;
        issue_addr  = '0;
        wb_valid    = '0;
        wb_addr     = '0;
        err_clr     = 1'b0;
        test_reset();
        test_basic();
        test_waw();
        test_collision();
        test_reg0();
        test_random();
        test_reset_mid();
`ifdef SB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end

endmodule
